// File: rtl/pipeline_control_pkg.sv
// Core-wide definitions shared by the pipeline controller and its helpers:
// PC-select encodings, controller states, and the control-bundle type.
package pipeline_control_pkg;

  localparam int REG_IDX_W = 5;

  typedef enum logic [1:0] {
    PC_PREDICT = 2'b00,
    PC_RA      = 2'b01,
    PC_EX      = 2'b10,
    PC_HOLD    = 2'b11
  } pc_sel_e;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_FLUSH,
    ST_MEM_WAIT,
    ST_DRAIN,
    ST_HALTED
  } state_e;

  typedef struct packed {
    logic    stall_fd;
    logic    stall_ra;
    logic    stall_ex;
    logic    stall_ma;
    logic    bubble_ex;
    logic    flush_fd;
    logic    flush_ra;
    logic    halted;
    pc_sel_e pc_sel;
    logic    flush_inc;
  } ctl_t;

  localparam ctl_t CTL_IDLE = '{
    stall_fd: 1'b0, stall_ra: 1'b0, stall_ex: 1'b0, stall_ma: 1'b0,
    bubble_ex: 1'b0, flush_fd: 1'b0, flush_ra: 1'b0, halted: 1'b0,
    pc_sel: PC_PREDICT, flush_inc: 1'b0
  };

  localparam ctl_t CTL_FREEZE = '{
    stall_fd: 1'b1, stall_ra: 1'b1, stall_ex: 1'b1, stall_ma: 1'b1,
    bubble_ex: 1'b0, flush_fd: 1'b0, flush_ra: 1'b0, halted: 1'b0,
    pc_sel: PC_HOLD, flush_inc: 1'b0
  };

endpackage

// File: rtl/pipeline_control_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_control.sv
// Hazard and sequencing controller for the five-stage core: stalls, bubbles,
// flushes, fetch PC-select, debug halt sequencing and performance counters.
module pipeline_control
  import pipeline_control_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [REG_IDX_W-1:0] ra_rs_a,
  input  logic [REG_IDX_W-1:0] ra_rs_b,
  input  logic                 ra_use_a,
  input  logic                 ra_use_b,
  input  logic                 ra_redirect,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_is_load,
  input  logic                 ex_mispredict,
  input  logic                 dmem_busy,
  input  logic                 halt_req,
  input  logic                 resume,
  output logic                 stall_fd,
  output logic                 stall_ra,
  output logic                 stall_ex,
  output logic                 stall_ma,
  output logic                 bubble_ex,
  output logic                 flush_fd,
  output logic                 flush_ra,
  output logic [1:0]           pc_sel,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] flush_count
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  state_e        state, state_next, run_next;
  logic [DW-1:0] drain_cnt, drain_next;
  ctl_t          run_ctl, ctl;
  logic          load_use;

  always_comb begin
    load_use = ex_is_load && (ex_rd != '0) &&
               ((ra_use_a && (ra_rs_a == ex_rd)) ||
                (ra_use_b && (ra_rs_b == ex_rd)));
  end

  // RUN decision, also reused by MEM_WAIT on the cycle dmem_busy drops.
  always_comb begin
    run_ctl  = CTL_IDLE;
    run_next = ST_RUN;
    if (dmem_busy) begin
      run_ctl  = CTL_FREEZE;
      run_next = ST_MEM_WAIT;
    end else if (ex_mispredict) begin
      run_ctl.flush_fd  = 1'b1;
      run_ctl.flush_ra  = 1'b1;
      run_ctl.pc_sel    = PC_EX;
      run_ctl.flush_inc = 1'b1;
      run_next          = ST_FLUSH;
    end else if (ra_redirect) begin
      run_ctl.flush_fd  = 1'b1;
      run_ctl.pc_sel    = PC_RA;
      run_ctl.flush_inc = 1'b1;
    end else if (load_use) begin
      run_ctl.stall_fd  = 1'b1;
      run_ctl.stall_ra  = 1'b1;
      run_ctl.bubble_ex = 1'b1;
      run_ctl.pc_sel    = PC_HOLD;
    end else if (halt_req) begin
      run_next = ST_DRAIN;
    end
  end

  always_comb begin
    ctl        = CTL_IDLE;
    state_next = state;
    drain_next = drain_cnt;
    case (state)
      ST_RUN: begin
        ctl        = run_ctl;
        state_next = run_next;
        drain_next = '0;
      end
      ST_FLUSH: begin
        if (dmem_busy) begin
          ctl        = CTL_FREEZE;
          state_next = ST_MEM_WAIT;
        end else begin
          state_next = ST_RUN;
        end
        ctl.flush_ra = 1'b1;
      end
      ST_MEM_WAIT: begin
        if (dmem_busy) begin
          ctl = CTL_FREEZE;
        end else begin
          ctl        = run_ctl;
          state_next = run_next;
          drain_next = '0;
        end
      end
      ST_DRAIN: begin
        if (dmem_busy) begin
          ctl = CTL_FREEZE;
        end else begin
          ctl.stall_fd  = 1'b1;
          ctl.bubble_ex = 1'b1;
          ctl.pc_sel    = PC_HOLD;
          if (ex_mispredict) begin
            ctl.flush_fd  = 1'b1;
            ctl.flush_ra  = 1'b1;
            ctl.pc_sel    = PC_EX;
            ctl.flush_inc = 1'b1;
          end
          if (drain_cnt == DRAIN_LAST) begin
            state_next = ST_HALTED;
          end else begin
            drain_next = drain_cnt + 1'b1;
          end
        end
      end
      ST_HALTED: begin
        ctl        = CTL_FREEZE;
        ctl.halted = 1'b1;
        if (resume) begin
          state_next = ST_RUN;
        end
      end
      default: state_next = ST_RUN;
    endcase
    if (reset) begin
      ctl = CTL_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_RUN;
      drain_cnt <= '0;
    end else begin
      state     <= state_next;
      drain_cnt <= drain_next;
    end
  end

  assign stall_fd  = ctl.stall_fd;
  assign stall_ra  = ctl.stall_ra;
  assign stall_ex  = ctl.stall_ex;
  assign stall_ma  = ctl.stall_ma;
  assign bubble_ex = ctl.bubble_ex;
  assign flush_fd  = ctl.flush_fd;
  assign flush_ra  = ctl.flush_ra;
  assign pc_sel    = ctl.pc_sel;
  assign halted    = ctl.halted;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (ctl.stall_fd),
    .count (stall_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (ctl.flush_inc),
    .count (flush_count)
  );

endmodule

// File: tb/tb_pipeline_control.sv
// Scoreboard bench for pipeline_control: each driven cycle queues its expected
// control vector and counter values; the negedge monitor pops and compares.
module tb_pipeline_control;

  localparam logic [9:0] IDLE     = 10'b0000000000;
  localparam logic [9:0] LU       = 10'b1100100011;
  localparam logic [9:0] FRZ      = 10'b1111000011;
  localparam logic [9:0] FRZ_FL   = 10'b1111001011;
  localparam logic [9:0] MISP     = 10'b0000011010;
  localparam logic [9:0] FL1      = 10'b0000001000;
  localparam logic [9:0] RAR      = 10'b0000010001;
  localparam logic [9:0] DRN      = 10'b1000100011;
  localparam logic [9:0] DRN_MISP = 10'b1000111010;
  localparam logic [9:0] HLT      = 10'b1111000111;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] ra_rs_a, ra_rs_b, ex_rd;
  logic       ra_use_a, ra_use_b, ra_redirect, ex_is_load, ex_mispredict;
  logic       dmem_busy, halt_req, resume;
  logic       stall_fd, stall_ra, stall_ex, stall_ma, bubble_ex;
  logic       flush_fd, flush_ra, halted;
  logic [1:0] pc_sel;
  logic [3:0] stall_count, flush_count;

  typedef struct {
    string      tag;
    logic [9:0] ctl;
    logic [3:0] sc;
    logic [3:0] fc;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] m_sc, m_fc;
  int         checks = 0;
  int         errors = 0;

  pipeline_control #(.DRAIN_CYCLES(3), .CNT_WIDTH(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .ra_rs_a       (ra_rs_a),
    .ra_rs_b       (ra_rs_b),
    .ra_use_a      (ra_use_a),
    .ra_use_b      (ra_use_b),
    .ra_redirect   (ra_redirect),
    .ex_rd         (ex_rd),
    .ex_is_load    (ex_is_load),
    .ex_mispredict (ex_mispredict),
    .dmem_busy     (dmem_busy),
    .halt_req      (halt_req),
    .resume        (resume),
    .stall_fd      (stall_fd),
    .stall_ra      (stall_ra),
    .stall_ex      (stall_ex),
    .stall_ma      (stall_ma),
    .bubble_ex     (bubble_ex),
    .flush_fd      (flush_fd),
    .flush_ra      (flush_ra),
    .pc_sel        (pc_sel),
    .halted        (halted),
    .stall_count   (stall_count),
    .flush_count   (flush_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  task automatic push(input string tag, input logic [9:0] c);
    exp_t e;
    e.tag = tag;
    e.ctl = c;
    e.sc  = m_sc;
    e.fc  = m_fc;
    sb.push_back(e);
    if (c[9]) m_sc = sat_inc(m_sc);
    if (c[1:0] == 2'b10 || c[1:0] == 2'b01) m_fc = sat_inc(m_fc);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    ra_rs_a = '0; ra_rs_b = '0; ex_rd = '0;
    ra_use_a = 0; ra_use_b = 0; ra_redirect = 0; ex_is_load = 0;
    ex_mispredict = 0; dmem_busy = 0; halt_req = 0; resume = 0;
  endtask

  task automatic set_lu();
    ex_is_load = 1; ex_rd = 5'd5; ra_use_a = 1; ra_rs_a = 5'd5;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check({e.tag, "_ctl"},
            {22'd0, stall_fd, stall_ra, stall_ex, stall_ma, bubble_ex,
             flush_fd, flush_ra, halted, pc_sel}, {22'd0, e.ctl});
      check({e.tag, "_stall_count"}, {28'd0, stall_count}, {28'd0, e.sc});
      check({e.tag, "_flush_count"}, {28'd0, flush_count}, {28'd0, e.fc});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    reset = 1;
    m_sc = '0;
    m_fc = '0;
    next(); push("reset", IDLE);
    next(); reset = 0; push("idle", IDLE);

    // load-use on rs_a, then released
    next(); set_lu(); push("lu_a", LU);
    next(); ex_is_load = 0; push("lu_release", IDLE);
    // destination x0 never interlocks
    next(); ex_is_load = 1; ex_rd = '0; ra_rs_a = '0; push("lu_x0", IDLE);
    // load-use on rs_b only
    next(); clr(); ex_is_load = 1; ex_rd = 5'd7; ra_use_b = 1; ra_rs_b = 5'd7; push("lu_b", LU);
    // rs_b matches but not used
    next(); ra_use_b = 0; push("lu_b_unused", IDLE);

    // mispredict: flush, one FLUSH cycle, back to RUN
    next(); clr(); ex_mispredict = 1; push("misp0", MISP);
    next(); ex_mispredict = 0; push("misp1", FL1);
    next(); push("misp2", IDLE);

    // dmem_busy dominates mispredict and load-use; mispredict re-evaluated after
    next(); set_lu(); ex_mispredict = 1; dmem_busy = 1; push("prio_busy0", FRZ);
    for (int i = 0; i < 3; i++) begin
      next(); push("prio_wait", FRZ);
    end
    next(); dmem_busy = 0; push("prio_release", MISP);
    next(); clr(); push("prio_flush", FL1);
    next(); push("prio_run", IDLE);

    // dmem_busy during FLUSH keeps flush_ra and freezes
    next(); ex_mispredict = 1; push("fb_misp", MISP);
    next(); ex_mispredict = 0; dmem_busy = 1; push("fb_flush_busy", FRZ_FL);
    next(); dmem_busy = 0; push("fb_release", IDLE);

    // RA redirect beats load-use
    next(); set_lu(); ra_redirect = 1; push("rar_vs_lu", RAR);
    next(); clr(); push("rar_done", IDLE);

    // halt pulse: 3 drain cycles then halted; single-step via resume with halt held
    next(); halt_req = 1; push("halt_run", IDLE);
    next(); halt_req = 0; push("drain0", DRN);
    next(); push("drain1", DRN);
    next(); push("drain2", DRN);
    next(); push("halted0", HLT);
    next(); resume = 1; halt_req = 1; push("step_resume", HLT);
    next(); resume = 0; push("step_run", IDLE);
    next(); halt_req = 0; push("step_drain0", DRN);
    next(); push("step_drain1", DRN);
    next(); push("step_drain2", DRN);
    next(); push("step_halted", HLT);
    next(); resume = 1; push("resume", HLT);
    next(); resume = 0; push("resumed", IDLE);

    // drain frozen by dmem_busy, mispredict in drain does not restart it
    next(); halt_req = 1; push("d2_run", IDLE);
    next(); halt_req = 0; push("d2_drain0", DRN);
    next(); dmem_busy = 1; push("d2_busy", FRZ);
    next(); dmem_busy = 0; ex_mispredict = 1; push("d2_misp", DRN_MISP);
    next(); ex_mispredict = 0; push("d2_drain2", DRN);
    next(); push("d2_halted", HLT);
    next(); resume = 1; push("d2_resume", HLT);
    next(); resume = 0; push("d2_run_again", IDLE);

    // saturate the 4-bit stall counter
    for (int i = 0; i < 20; i++) begin
      next(); set_lu(); push("lu_sat", LU);
    end
    next(); clr(); push("sat_hold", IDLE);

    // reset while halted
    next(); halt_req = 1; push("r_run", IDLE);
    next(); halt_req = 0; push("r_drain0", DRN);
    next(); push("r_drain1", DRN);
    next(); push("r_drain2", DRN);
    next(); push("r_halted", HLT);
    next(); reset = 1; push("r_reset", IDLE);
    m_sc = '0;
    m_fc = '0;
    next(); reset = 0; push("r_after", IDLE);
    next(); push("r_idle", IDLE);

    repeat (2) @(negedge clk);
    #1;
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_control.md
Name: pipeline_control

Overview:
- Central hazard and sequencing controller for the five-stage core (fetch/decode, register access, execute, memory access, write back).
- Issues stall, bubble and flush commands and the fetch PC-select.
- Arbitrates simultaneous hazard sources: data-memory wait, execute mispredict, register-access jalr/ret redirect, load-use interlock, and debug halt/resume.
- Instantiated once in the core top; also exposes performance counters.

Parameters:
- DRAIN_CYCLES, 3, cycles spent in DRAIN before HALTED (covers in-flight EX/MA/WB).
- CNT_WIDTH, 32, width of the saturating stall and flush counters.

Ports:
- clk  input  1  core clock
- reset  input  1  synchronous, active-high reset
- ra_rs_a  input  5  source register A of the instruction in register access
- ra_rs_b  input  5  source register B of the instruction in register access
- ra_use_a  input  1  instruction in register access reads rs_a
- ra_use_b  input  1  instruction in register access reads rs_b
- ra_redirect  input  1  jalr/ret resolved in register access; target is stage_r_pc
- ex_rd  input  5  destination register of the instruction in execute
- ex_is_load  input  1  instruction in execute is a load (read_status != 0)
- ex_mispredict  input  1  branch mispredict resolved in execute
- dmem_busy  input  1  memory access stage not ready; freeze the pipeline
- halt_req  input  1  debug halt request, level
- resume  input  1  debug resume, single-cycle pulse
- stall_fd  output  1  hold PC and fetch/decode registers
- stall_ra  output  1  hold register-access registers
- stall_ex  output  1  hold execute registers
- stall_ma  output  1  hold memory-access registers
- bubble_ex  output  1  load a NOP into execute next edge
- flush_fd  output  1  kill the instruction in fetch/decode
- flush_ra  output  1  kill the instructions in register access and execute inputs
- pc_sel  output  2  00 predict, 01 RA redirect, 10 EX redirect, 11 hold
- halted  output  1  core is halted
- stall_count  output  CNT_WIDTH  cycles with stall_fd=1, saturating
- flush_count  output  CNT_WIDTH  accepted redirects (EX or RA), saturating

Behaviour:
- States: RUN, FLUSH, MEM_WAIT, DRAIN, HALTED. Outputs are combinational from state and inputs; state and counters are registered.
- Reset: state RUN, drain counter 0, stall_count and flush_count 0. While reset is high, all control outputs are 0 and pc_sel is 00.
- Hazard terms:
  - load_use = ex_is_load & ex_rd!=0 & ((ra_use_a & ra_rs_a==ex_rd) | (ra_use_b & ra_rs_b==ex_rd)).
  - Priority, highest first: dmem_busy > ex_mispredict > ra_redirect > load_use.
- RUN:
  - dmem_busy: all four stalls 1, pc_sel 11, go to MEM_WAIT.
  - Else ex_mispredict: flush_fd=1, flush_ra=1, pc_sel 10, flush_count++, go to FLUSH.
  - Else ra_redirect: flush_fd=1, pc_sel 01, flush_count++, stay in RUN.
  - Else load_use: stall_fd=1, stall_ra=1, bubble_ex=1, pc_sel 11, stay in RUN. A one-cycle stall is sufficient because MA forwarding then covers the load.
  - Else if halt_req: go to DRAIN with drain counter 0 (pc_sel 00 in this cycle).
  - Else all outputs 0, pc_sel 00.
- FLUSH (exactly one cycle):
  - flush_ra=1 kills the wrong-path instruction already fetched due to IMEM latency; pc_sel 00.
  - Next state is RUN. If dmem_busy is high in this cycle, go to MEM_WAIT instead with the stall outputs, and flush_ra stays 1 for this cycle.
- MEM_WAIT:
  - All four stalls 1, pc_sel 11; ex_mispredict, ra_redirect, load_use and halt_req are ignored.
  - Frozen stages hold their signals stable, so these events are re-evaluated on the first cycle in RUN.
  - Return to RUN when dmem_busy=0 (that cycle is evaluated as RUN without dmem_busy).
- DRAIN:
  - stall_fd=1, bubble_ex=1, pc_sel 11; drain counter increments each cycle.
  - At count DRAIN_CYCLES-1, go to HALTED.
  - ex_mispredict in DRAIN: flush_fd, flush_ra, pc_sel 10 and flush_count++ apply for that cycle; the drain counter is not reset.
  - dmem_busy in DRAIN freezes the drain counter and asserts all four stalls.
  - halt_req dropping in DRAIN does not abort the drain.
- HALTED:
  - All four stalls 1, pc_sel 11, halted=1.
  - resume (with halt_req=0 or 1) goes to RUN next edge.
  - If halt_req is still 1 at the first RUN cycle, re-enter DRAIN. This allows single-stepping by pulsing resume.
- Counters: stall_count increments on every cycle with stall_fd=1. Both counters saturate at all-ones and never wrap.
- Reset mid-operation from any state returns to RUN next edge with counters cleared.

Decomposition:
- Shared package (core-wide):
  - pc_sel encodings: PC_PREDICT, PC_RA, PC_EX, PC_HOLD.
  - State encoding.
  - Register index width 5.
- One sub-module, sat_counter (parameter WIDTH; inputs inc and clear), instantiated twice.
- Hazard detection stays inline.

Test Plan:
- Load-use: ex_is_load=1, ex_rd=5, ra_use_a=1, ra_rs_a=5 -> same cycle stall_fd=stall_ra=bubble_ex=1, pc_sel=11; next cycle with ex_is_load=0, outputs 0 and stall_count=1. Repeat with ex_rd=0 -> no stall.
- Mispredict: ex_mispredict=1 in RUN -> cycle 0: flush_fd=flush_ra=1, pc_sel=10; cycle 1: flush_ra=1 only, pc_sel=00; cycle 2: RUN, flush_count=1.
- Priority: dmem_busy=1 with ex_mispredict=1 and load_use true -> all stalls 1, pc_sel=11, no flush. Hold for 4 cycles, then dmem_busy=0 with mispredict still high -> flush issued on that cycle.
- Redirect versus load-use: ra_redirect=1 and load_use true -> flush_fd=1, pc_sel=01, no bubble_ex.
- Halt: halt_req=1 for 1 cycle -> DRAIN for 3 cycles (stall_fd=1, bubble_ex=1), then halted=1 with all stalls. resume pulse -> RUN next cycle, halted=0.
- Saturation and reset: with CNT_WIDTH=4, force 20 load-use stalls -> stall_count=15. Assert reset in HALTED -> next cycle halted=0, counters 0, outputs 0.
